// File: rtl/mdu_stage_e.sv
// Execute-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, single-cycle MTHI/MTLO.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_stage_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        MdStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Busy is the state itself: RUN means a multi-cycle result is pending.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic is_mul, is_div, is_madd, is_multi, op_signed;
  logic [63:0] a_ext, b_ext, product, mul_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  assign is_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
  assign is_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign op_signed = ~Op[0];

  // Sign-extending to 64 bits makes the low 64 bits of one multiplier correct for both signednesses.
  assign a_ext   = {{32{op_signed & A[31]}}, A};
  assign b_ext   = {{32{op_signed & B[31]}}, B};
  assign product = a_ext * b_ext;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign is_madd = Op[2] & Op[1];
  assign acc     = {hi_q, lo_q} + product;
  assign mul_res = is_madd ? acc : product;
`else
  assign is_madd = 1'b0;
  assign mul_res = product;
`endif

  assign is_multi = is_mul | is_div | is_madd;

  // Signed divide works on magnitudes; the 0x80000000 / -1 case falls out naturally.
  assign a_neg   = op_signed & A[31];
  assign b_neg   = op_signed & B[31];
  assign a_mag   = a_neg ? -A : A;
  assign b_mag   = b_neg ? -B : B;
  assign div_den = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / div_den;
  assign r_mag   = a_mag % div_den;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_hi = mul_res[63:32];
    res_lo = mul_res[31:0];
    if (is_div) begin
      if (B == 32'd0) begin
        res_hi = A;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (is_multi) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d   = RUN;
          end else if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign MdStall = Busy | (Start & is_multi);
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_stage_e.sv
// Bench for mdu_stage_e: directed cases with literal expectations plus randomized traffic against a
// commit-schedule model. Honors MDU_MADD_EN the same way as the design.
module tb_mdu_stage_e;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, mdstall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mdu_stage_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .MdStall(mdstall), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit multi_op(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o <= 3'd3) || (o >= 3'd6);
`else
    return (o <= 3'd3);
`endif
  endfunction

  // Returns {HI,LO} as the arithmetic rules define them.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                             input logic [63:0] hilo);
    int sx, sy;
    longint p;
    logic [63:0] r;
    sx = x;
    sy = y;
    p  = longint'(sx) * longint'(sy);
    r  = hilo;
    case (o)
      3'd0: r = p;
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      3'd6: r = hilo + 64'(p);
      3'd7: r = hilo + {32'd0, x} * {32'd0, y};
      default: r = hilo;
    endcase
    return r;
  endfunction

  // Model: a pending result is due at a known edge number; Busy is simply "a result is pending".
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  bit          m_pending = 1'b0;
  int          edge_no = 0, commit_at = 0;

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_pending = 1'b0;
    end else if (m_pending) begin
      if (edge_no == commit_at) begin
        {m_hi, m_lo} = m_pend;
        m_pending = 1'b0;
      end
    end else if (start) begin
      if (multi_op(op)) begin
        m_pend    = ref_result(op, a, b, {m_hi, m_lo});
        commit_at = edge_no + ((op == 3'd2 || op == 3'd3) ? DC : MC);
        m_pending = 1'b1;
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_pending);
      chk("mdstall", mdstall, m_pending | (start & multi_op(op)));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(c);
    chk("mult_cycles", 32'(c), 32'd5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    issue(3'd3, 32'd100, 32'd7);
    wait_idle(c);
    chk("divu_cycles", 32'(c), 32'd10);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(c);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'd2, 32'h12, 32'd0);
    wait_idle(c);
    chk("div_zero_hilo", {hi, lo}, {32'h12, 32'hFFFF_FFFF});

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    chk("div_ovf_hilo", {hi, lo}, {32'h0, 32'h8000_0000});

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    issue(3'd5, 32'd1, 32'd0);
    wait_idle(c);
    chk("multu_ignore_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

    issue(3'd4, 32'hABCD, 32'd0);
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_busy", busy, 1'b0);
    issue(3'd0, 32'd2, 32'd3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", busy, 1'b0);
    repeat (12) tick();
    chk("abort_nocommit", {hi, lo}, 64'd0);

    issue(3'd5, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
    wait_idle(c);
`ifdef MDU_MADD_EN
    chk("maddu_cycles", 32'(c), 32'd5);
    chk("maddu_hilo", {hi, lo}, {32'd1, 32'd0});
`else
    chk("maddu_cycles", 32'(c), 32'd0);
    chk("maddu_hilo", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
      tick();
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (15) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
